// File: rtl/hls_ap_ctrl_sequencer.sv
// hls_ap_ctrl_sequencer
// Drives an HLS kernel through its ap_ctrl_hs handshake. It launches a
// programmed number of runs separated by a fixed idle gap, and a watchdog
// parks the sequencer in an error state if a run never completes.
// status_o = {err_timeout, busy, fin} feeds the board LEDs directly.

module hls_ap_ctrl_sequencer #(
  parameter int CNT_W          = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_go,
  input  logic [CNT_W-1:0] cfg_runs,
  input  logic             cfg_abort,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_idle,
  output logic             busy,
  output logic [CNT_W-1:0] runs_done,
  output logic             err_timeout,
  output logic [2:0]       status_o
);

  // Gap counter runs 0 .. GAP_CYCLES-1; a zero gap still spends one cycle
  // in GAP, which keeps the GAP -> WAIT_IDLE path identical for all values.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST =
      (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_START,
    S_RUN,
    S_GAP,
    S_DONE,
    S_ERR
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] runs_done_q;
  logic [TO_W-1:0]  wdog_q;
  logic [GAP_W-1:0] gap_q;
  logic             ap_start_q;
  logic             busy_q;
  logic             fin_q;
  logic             err_q;
  logic             abort_pend_q;

  // Decode helpers computed from the current state and sampled inputs.
  logic             start_hs;
  logic             kernel_done;
  logic             launch_ok;
  logic             stop_req;
  logic             target_hit;
  logic [CNT_W-1:0] runs_inc;
  logic [TO_W-1:0]  wdog_inc;

  // Handshake, completion and saturation decode feeding the FSM.
  always_comb begin
    start_hs    = (state_q == S_START) && ap_ready;
    // A done is only meaningful once the start has been accepted: either
    // already in RUN, or accepted on this very edge.
    kernel_done = ap_done && ((state_q == S_RUN) || start_hs);
    launch_ok   = cfg_go && !cfg_abort;
    stop_req    = abort_pend_q || cfg_abort;
    runs_inc    = (&runs_done_q) ? runs_done_q : runs_done_q + CNT_W'(1);
    target_hit  = (target_q != '0) && (runs_inc == target_q);
    wdog_inc    = wdog_q + TO_W'(1);
  end

  // Sequencer FSM; every output is a flop updated alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      runs_done_q  <= '0;
      wdog_q       <= '0;
      gap_q        <= '0;
      ap_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      fin_q        <= 1'b0;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      case (state_q)
        // IDLE and ERR accept a launch the same way; a simultaneous abort
        // suppresses it.
        S_IDLE, S_ERR: begin
          if (launch_ok) begin
            state_q      <= S_WAIT_IDLE;
            target_q     <= cfg_runs;
            runs_done_q  <= '0;
            fin_q        <= 1'b0;
            err_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end

        S_WAIT_IDLE: begin
          if (cfg_abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (ap_idle) begin
            state_q    <= S_START;
            ap_start_q <= 1'b1;
            wdog_q     <= '0;
          end
        end

        // START and RUN share completion and watchdog handling. An abort
        // here is only remembered: the handshake in flight is finished.
        S_START, S_RUN: begin
          if (kernel_done) begin
            runs_done_q  <= runs_inc;
            ap_start_q   <= 1'b0;
            abort_pend_q <= 1'b0;
            if (target_hit) begin
              // Reaching the target wins over a pending abort so fin is set.
              state_q <= S_DONE;
            end else if (stop_req) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_GAP;
              gap_q   <= '0;
            end
          end else if (wdog_inc == TO_LIMIT) begin
            state_q      <= S_ERR;
            ap_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b1;
            abort_pend_q <= 1'b0;
          end else begin
            wdog_q <= wdog_inc;
            if (cfg_abort) begin
              abort_pend_q <= 1'b1;
            end
            if (start_hs) begin
              state_q    <= S_RUN;
              ap_start_q <= 1'b0;
            end
          end
        end

        S_GAP: begin
          if (cfg_abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (gap_q == GAP_LAST) begin
            state_q <= S_WAIT_IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        // Single-cycle completion state; fin and busy change together.
        S_DONE: begin
          state_q <= S_IDLE;
          fin_q   <= 1'b1;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q    <= S_IDLE;
          ap_start_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign ap_start    = ap_start_q;
  assign busy        = busy_q;
  assign runs_done   = runs_done_q;
  assign err_timeout = err_q;
  assign status_o    = {err_q, busy_q, fin_q};

endmodule

// File: tb/tb_hls_ap_ctrl_sequencer.sv
// tb_hls_ap_ctrl_sequencer
// Directed stimulus with a behavioural kernel model. Expected handshake and
// end-of-sequence records are queued by the stimulus and consumed by a
// negedge monitor whenever the DUT presents the corresponding event.

module tb_hls_ap_ctrl_sequencer;

  localparam int CNT_W   = 16;
  localparam int GAP     = 8;
  localparam int TIMEOUT = 1024;
  localparam int TO_W    = 16;

  logic             clk;
  logic             rst;
  logic             cfg_go;
  logic [CNT_W-1:0] cfg_runs;
  logic             cfg_abort;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_idle;
  logic             busy;
  logic [CNT_W-1:0] runs_done;
  logic             err_timeout;
  logic [2:0]       status_o;

  hls_ap_ctrl_sequencer #(
    .CNT_W         (CNT_W),
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(TIMEOUT),
    .TO_W          (TO_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_go     (cfg_go),
    .cfg_runs   (cfg_runs),
    .cfg_abort  (cfg_abort),
    .ap_start   (ap_start),
    .ap_ready   (ap_ready),
    .ap_done    (ap_done),
    .ap_idle    (ap_idle),
    .busy       (busy),
    .runs_done  (runs_done),
    .err_timeout(err_timeout),
    .status_o   (status_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // Scoreboard records. gap/elapsed of -1 mean "not checked".
  typedef struct {int len; int runs; int start_after; int gap;} hs_t;
  typedef struct {int runs; int status; int start; int elapsed;} end_t;
  hs_t  hs_q[$];
  end_t end_q[$];

  task automatic exp_hs(input int len, input int runs, input int gap);
    hs_t e;
    e.len = len; e.runs = runs; e.start_after = 0; e.gap = gap;
    hs_q.push_back(e);
  endtask

  task automatic exp_end(input int runs, input int status, input int elapsed);
    end_t e;
    e.runs = runs; e.status = status; e.start = 0; e.elapsed = elapsed;
    end_q.push_back(e);
  endtask

  // Kernel model, acting 1 time unit after each rising edge.
  int k_ready_dly = 0;
  int k_done_dly  = 20;
  bit k_together  = 1'b0;
  bit k_abandon   = 1'b0;
  int kph = 0;
  int kcnt = 0;

  initial begin
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    ap_idle  = 1'b1;
  end

  always @(posedge clk) begin
    #1;
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    if (rst || k_abandon) begin
      kph = 0;
      ap_idle = 1'b1;
    end else begin
      if (kph == 0 && ap_start) begin
        kph = 1;
        kcnt = k_ready_dly;
      end
      if (kph == 1) begin
        if (kcnt == 0) begin
          ap_ready = 1'b1;
          if (k_together) begin
            ap_done = 1'b1;
            kph = 0;
          end else begin
            ap_idle = 1'b0;
            kph = 2;
            kcnt = k_done_dly;
          end
        end else begin
          kcnt--;
        end
      end else if (kph == 2) begin
        if (kcnt > 0) begin
          kcnt--;
          if (kcnt == 0) begin
            ap_done = 1'b1;
            ap_idle = 1'b1;
            kph = 0;
          end
        end
      end
    end
  end

  // Monitor: samples on the falling edge.
  int   cyc = 0;
  int   start_cyc = 0;
  int   done_cyc = 0;
  bit   prev_start = 1'b0;
  bit   prev_busy = 1'b0;
  bit   hs_pend = 1'b0;
  hs_t  hs_got;
  hs_t  hs_exp;
  end_t end_got;
  end_t end_exp;

  always @(negedge clk) begin
    cyc++;
    if (hs_pend) begin
      hs_pend = 1'b0;
      hs_got.start_after = int'(ap_start);
      $display("HS  len=%0d runs=%0d start_after=%0d gap=%0d", hs_got.len, hs_got.runs,
               hs_got.start_after, hs_got.gap);
      if (hs_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL hs_unexpected actual=handshake required=none");
      end else begin
        hs_exp = hs_q.pop_front();
        check("hs_len", hs_got.len, hs_exp.len);
        check("hs_runs", hs_got.runs, hs_exp.runs);
        check("hs_start_after", hs_got.start_after, hs_exp.start_after);
        if (hs_exp.gap >= 0) check("hs_gap", hs_got.gap, hs_exp.gap);
      end
    end
    if (ap_start === 1'b1 && !prev_start) start_cyc = cyc;
    if (ap_start === 1'b1 && ap_ready === 1'b1) begin
      hs_pend = 1'b1;
      hs_got.len = cyc - start_cyc + 1;
      hs_got.runs = int'(runs_done);
      hs_got.gap = start_cyc - done_cyc;
    end
    if (ap_done === 1'b1) done_cyc = cyc;
    if (prev_busy && busy === 1'b0) begin
      end_got.runs = int'(runs_done);
      end_got.status = int'(status_o);
      end_got.start = int'(ap_start);
      end_got.elapsed = cyc - start_cyc;
      $display("END runs=%0d status=%0d ap_start=%0d elapsed=%0d", end_got.runs,
               end_got.status, end_got.start, end_got.elapsed);
      if (end_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL end_unexpected actual=busy_fall required=none");
      end else begin
        end_exp = end_q.pop_front();
        check("end_runs", end_got.runs, end_exp.runs);
        check("end_status", end_got.status, end_exp.status);
        check("end_ap_start", end_got.start, end_exp.start);
        if (end_exp.elapsed >= 0) check("end_elapsed", end_got.elapsed, end_exp.elapsed);
      end
    end
    prev_start = (ap_start === 1'b1);
    prev_busy  = (busy === 1'b1);
  end

  // Stimulus helpers: all drives happen 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [CNT_W-1:0] runs);
    cfg_runs = runs;
    cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
  endtask

  task automatic pulse_abort();
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_idle_wait"}, int'(n < budget), 1);
    repeat (3) tick();
  endtask

  task automatic wait_start(input string name, input int budget);
    int n = 0;
    while (ap_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_start_wait"}, int'(n < budget), 1);
  endtask

  task automatic wait_runs(input string name, input int val, input int budget);
    int n = 0;
    while (int'(runs_done) != val && n < budget) begin
      tick();
      n++;
    end
    check({name, "_runs_wait"}, int'(n < budget), 1);
  endtask

  initial begin
    rst = 1'b1;
    cfg_go = 1'b0;
    cfg_runs = '0;
    cfg_abort = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_ap_start", int'(ap_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_runs_done", int'(runs_done), 0);
    check("rst_status", int'(status_o), 0);

    // Three runs, ready after 1 cycle, done 20 cycles later.
    exp_hs(1, 0, -1);
    exp_hs(1, 1, GAP + 2);
    exp_hs(1, 2, GAP + 2);
    exp_end(3, 3'b001, 22);
    launch(16'd3);
    wait_idle("t1", 500);

    // ap_ready held low for 5 cycles.
    k_ready_dly = 5;
    exp_hs(6, 0, -1);
    exp_end(1, 3'b001, 27);
    launch(16'd1);
    wait_idle("t2", 200);
    k_ready_dly = 0;

    // ap_ready and ap_done together.
    k_together = 1'b1;
    exp_hs(1, 0, -1);
    exp_hs(1, 1, GAP + 2);
    exp_end(2, 3'b001, 2);
    launch(16'd2);
    wait_idle("t3", 200);
    k_together = 1'b0;

    // Kernel never finishes: watchdog error, then a relaunch clears it.
    k_done_dly = -1;
    exp_hs(1, 0, -1);
    exp_end(0, 3'b100, TIMEOUT);
    launch(16'd5);
    wait_idle("t4", TIMEOUT + 200);
    check("t4_err_flag", int'(err_timeout), 1);
    k_abandon = 1'b1;
    tick();
    k_abandon = 1'b0;
    k_done_dly = 20;
    exp_hs(1, 0, -1);
    exp_end(1, 3'b001, 22);
    launch(16'd1);
    wait_idle("t4b", 200);

    // Free run, abort during RUN: run still counted, fin stays 0.
    exp_hs(1, 0, -1);
    exp_end(1, 3'b000, 21);
    launch(16'd0);
    wait_start("t5a", 20);
    repeat (5) tick();
    pulse_abort();
    wait_idle("t5a", 200);

    // Free run, abort while START waits for ap_ready.
    k_ready_dly = 5;
    exp_hs(6, 0, -1);
    exp_end(1, 3'b000, 26);
    launch(16'd0);
    wait_start("t5c", 20);
    repeat (2) tick();
    pulse_abort();
    wait_idle("t5c", 200);
    k_ready_dly = 0;

    // Free run, abort during GAP: back to IDLE on the next edge.
    exp_hs(1, 0, -1);
    exp_end(1, 3'b000, 24);
    launch(16'd0);
    wait_runs("t5b", 1, 100);
    repeat (2) tick();
    pulse_abort();
    wait_idle("t5b", 100);

    // Target reached on the same done as a pending abort: fin is set.
    exp_hs(1, 0, -1);
    exp_end(1, 3'b001, 22);
    launch(16'd1);
    wait_start("t5d", 20);
    repeat (5) tick();
    pulse_abort();
    wait_idle("t5d", 200);

    // cfg_go together with cfg_abort in IDLE: nothing launches.
    cfg_runs = 16'd2;
    cfg_go = 1'b1;
    cfg_abort = 1'b1;
    tick();
    cfg_go = 1'b0;
    cfg_abort = 1'b0;
    repeat (5) tick();
    check("goabort_busy", int'(busy), 0);
    check("goabort_ap_start", int'(ap_start), 0);
    check("goabort_runs", int'(runs_done), 1);

    // Reset during the third run; a cfg_go while busy is ignored.
    exp_hs(1, 0, -1);
    exp_hs(1, 1, GAP + 2);
    exp_hs(1, 2, GAP + 2);
    exp_end(0, 3'b000, 6);
    launch(16'd5);
    repeat (6) tick();
    cfg_runs = 16'd1;
    cfg_go = 1'b1;
    tick();
    cfg_go = 1'b0;
    wait_runs("t6", 2, 200);
    wait_start("t6", 40);
    repeat (5) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("t6_runs_after_rst", int'(runs_done), 0);

    // Recovery after reset.
    exp_hs(1, 0, -1);
    exp_end(1, 3'b001, 22);
    launch(16'd1);
    wait_idle("t7", 200);

    repeat (4) tick();
    check("hs_queue_drained", hs_q.size(), 0);
    check("end_queue_drained", end_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so a stuck DUT cannot hang the run.
  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
